hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Multi-cycle multiply/divide engine and HI/LO register owner for the pipelined MIPS core. The ALU path reads HI/LO (mfhi/mflo); this block is the writer side. It accepts a mult/div/mthi/mtlo request from EX and iterates one bit per cycle. It commits the 64-bit result to HI/LO and produces a pipeline stall while EX needs a result that is not yet ready.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Start  in  1  request valid from EX, one cycle per instruction
Op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
OperandA  in  DATA_WIDTH  rs value, already forwarded
OperandB  in  DATA_WIDTH  rt value, already forwarded
HiLoReadReq  in  1  EX currently executing mfhi/mflo
Busy  out  1  iteration in progress
Done  out  1  one-cycle pulse: HI/LO just committed by mult/div
Stall  out  1  hold IF/ID/EX, bubble into MEM
Hi  out  DATA_WIDTH  HI register
Lo  out  DATA_WIDTH  LO register

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Hi=0, Lo=0, Busy=0, Done=0, Stall=0; counter and working registers cleared. Reset during CALC/FIX abandons the operation with no HI/LO write.
- FSM states:
  - IDLE: Start with Op 4/5 writes Hi/Lo=OperandA at that edge, stays IDLE, no Busy. Start with Op 0-3 (or 6/7) latches operands, converts signed operands to magnitudes and records result signs, sets counter=0, and moves to CALC.
  - CALC: one iteration per edge. Multiply uses shift-add on a 64-bit product. Divide is restoring division on a 2*DATA_WIDTH remainder/quotient pair. After DATA_WIDTH edges (counter = DATA_WIDTH-1 at the edge), move to FIX.
  - FIX: applies sign correction. At the leaving edge, commits Hi/Lo, registers Done=1 and returns to IDLE.
- Latency: Start sampled at edge N → Hi/Lo new and Done=1 in the cycle after edge N+DATA_WIDTH+1 (34 for 32). Busy=1 from after edge N until that same edge. Done is low otherwise.
- Mult results: Hi = product[63:32], Lo = product[31:0]. MULT is two's-complement; MULTU is unsigned.
- Div results: Lo = quotient, Hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV): Lo=0x80000000, Hi=0.
  - Divide by zero (either signedness): Lo=0xFFFFFFFF, Hi=OperandA. Still takes full latency.
- Stall = Busy & (HiLoReadReq | Start). Combinational from Busy, registered state only.
  - Start while Busy is ignored; EX re-presents it because Stall holds the pipeline.
  - HiLoReadReq in the Done cycle sees the committed values; no stall.
- Hi/Lo are direct register outputs; they are never partially updated during CALC.
- Op 6/7 without the feature enabled: treated as no-op, no state change.

Optional Feature:
MULDIV_MADD_EN: when defined, Op 6 (MADD) and Op 7 (MSUB) run signed multiply; FIX commits {Hi,Lo} ± product (64-bit wrap-around, no saturation). Same latency as MULT. When undefined, Ops 6/7 are ignored in IDLE (no Busy, no Done, Hi/Lo unchanged).

Decomposition:
- Package muldiv_pkg holds:
  - the Op encoding constants (OP_MULT..OP_MSUB);
  - the FSM state typedef (IDLE, CALC, FIX);
  - DIV0_LO constant 0xFFFFFFFF.
- One natural sub-module, muldiv_datapath, holds the iteration step: the shift-add / restoring-subtract step and sign fix, combinational.
- The FSM, counter and Hi/Lo registers stay in the top.

Test Plan:
1. Reset low mid-CALC of MULT → Hi=Lo=0, Busy=0, Done=0 immediately (asynchronous); after release, Done never pulses for the aborted op.
2. MULT A=0xFFFFFFFE(-2), B=0x00000003 → Done after 34 cycles; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. MULTU same operands → Hi=0x00000002, Lo=0xFFFFFFFA.
3. DIV A=0xFFFFFFF9(-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=0 → Lo=0xFFFFFFFF, Hi=7.
4. MULT started, HiLoReadReq=1 from cycle 2 → Stall=1 through cycle 33, Stall=0 in the Done cycle, and Hi/Lo are read correctly there.
5. MTLO A=0x12345678 while IDLE → Lo=0x12345678 next cycle, Busy never asserts. Start MULT while Busy → Stall=1, second op not latched until IDLE.
6. With MULDIV_MADD_EN: Hi=0, Lo=10, MADD 3×4 → Lo=22; MSUB 5×5 → {Hi,Lo}=0xFFFFFFFF_FFFFFFFD. Without the macro, Op 6 leaves Hi/Lo unchanged and Busy=0.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// FSM state type, accumulate-mode type and the divide-by-zero quotient.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // How the final product combines with the current {HI,LO}
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_t;

  // Quotient reported for a zero divisor (all ones)
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage request / status bundle between the pipeline and the HI/LO unit.
// i_* are driven by EX (master), o_* by the unit (slave).
interface hilo_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_operand_a;
  logic [DATA_WIDTH-1:0] i_operand_b;
  logic                  i_hilo_read_req;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_stall;
  logic [DATA_WIDTH-1:0] o_hi;
  logic [DATA_WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_operand_a, i_operand_b, i_hilo_read_req,
    input  o_busy, o_done, o_stall, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_operand_a, i_operand_b, i_hilo_read_req,
    output o_busy, o_done, o_stall, o_hi, o_lo
  );

endinterface

// File: rtl/hilo_muldiv_unit_datapath.sv
// Combinational iteration step and final sign correction for the
// multiply/divide engine. Works on magnitudes; signs are applied at the end.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_is_div,
  input  logic [2*DATA_WIDTH-1:0] i_work,
  input  logic [DATA_WIDTH-1:0]   i_mcand,
  input  logic                    i_neg_p,
  input  logic                    i_neg_r,
  input  logic                    i_div0,
  input  acc_t                    i_acc,
  input  logic [DATA_WIDTH-1:0]   i_hi,
  input  logic [DATA_WIDTH-1:0]   i_lo,
  output logic [2*DATA_WIDTH-1:0] o_work_next,
  output logic [DATA_WIDTH-1:0]   o_hi_fix,
  output logic [DATA_WIDTH-1:0]   o_lo_fix
);

  localparam int W = DATA_WIDTH;
  // All-ones at any width: sign-extend the package constant
  localparam logic [W-1:0] LO_DIV0 = W'($signed(DIV0_LO));

  logic [W:0]          w_mul_sum;
  logic [W:0]          w_rem_shift;
  logic [W:0]          w_rem_diff;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_acc;
  logic [W-1:0]        w_quot;
  logic [W-1:0]        w_rem;

  // One iteration: shift-add multiply (multiplier in low half, product grows
  // into the high half) or restoring divide ({remainder, quotient} pair).
  always_comb begin
    w_mul_sum   = {1'b0, i_work[2*W-1:W]} + (i_work[0] ? {1'b0, i_mcand} : '0);
    w_rem_shift = {i_work[2*W-1:W], i_work[W-1]};
    w_rem_diff  = w_rem_shift - {1'b0, i_mcand};
    if (i_is_div) begin
      // Top bit of the difference is the borrow: set means "restore"
      if (!w_rem_diff[W]) o_work_next = {w_rem_diff[W-1:0], i_work[W-2:0], 1'b1};
      else                o_work_next = {w_rem_shift[W-1:0], i_work[W-2:0], 1'b0};
    end else begin
      o_work_next = {w_mul_sum, i_work[W-1:1]};
    end
  end

  // Sign correction and optional accumulate into the current {HI,LO}.
  // A zero divisor leaves |A| as the remainder, so restoring the dividend
  // sign returns the original operand A in HI.
  always_comb begin
    w_prod = i_neg_p ? -$signed(i_work) : $signed(i_work);
    w_acc  = $signed({i_hi, i_lo});
    w_quot = i_neg_p ? -i_work[W-1:0] : i_work[W-1:0];
    w_rem  = i_neg_r ? -i_work[2*W-1:W] : i_work[2*W-1:W];
    case (i_acc)
      ACC_ADD: w_acc = w_acc + w_prod;
      ACC_SUB: w_acc = w_acc - w_prod;
      default: w_acc = w_prod;
    endcase
    if (i_is_div) begin
      o_hi_fix = w_rem;
      o_lo_fix = i_div0 ? LO_DIV0 : w_quot;
    end else begin
      o_hi_fix = w_acc[2*W-1:W];
      o_lo_fix = w_acc[W-1:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner and bit-serial multiply/divide engine for the MIPS
// pipeline. One bit per cycle, DATA_WIDTH iterations plus one sign-fix cycle.
// Optional: define MULDIV_MADD_EN to enable MADD/MSUB (ops 6/7); otherwise
// those ops are ignored.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  hilo_muldiv_unit_if.slave bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_work;
  logic [W-1:0]     r_mcand;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_is_div;
  logic             r_neg_p;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_done;
  acc_t             r_acc;

  logic             w_idle;
  logic             w_op_arith;
  logic             w_op_mac;
  logic             w_accept;
  logic             w_signed;
  logic             w_is_div_in;
  logic             w_sa;
  logic             w_sb;
  acc_t             w_acc_in;
  logic [W-1:0]     w_mag_a;
  logic [W-1:0]     w_mag_b;
  logic [2*W-1:0]   w_work_next;
  logic [W-1:0]     w_hi_fix;
  logic [W-1:0]     w_lo_fix;

  assign w_idle     = (r_state == IDLE);
  assign w_op_arith = (bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU) ||
                      (bus.i_op == OP_DIV)  || (bus.i_op == OP_DIVU);
`ifdef MULDIV_MADD_EN
  assign w_op_mac   = (bus.i_op == OP_MADD) || (bus.i_op == OP_MSUB);
`else
  assign w_op_mac   = 1'b0;
`endif
  assign w_accept    = bus.i_start && w_idle && (w_op_arith || w_op_mac);
  assign w_is_div_in = (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
  assign w_signed    = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV) || w_op_mac;
  assign w_sa        = w_signed && bus.i_operand_a[W-1];
  assign w_sb        = w_signed && bus.i_operand_b[W-1];
  assign w_mag_a     = w_sa ? -bus.i_operand_a : bus.i_operand_a;
  assign w_mag_b     = w_sb ? -bus.i_operand_b : bus.i_operand_b;
  assign w_acc_in    = !w_op_mac ? ACC_NONE :
                       (bus.i_op == OP_MSUB) ? ACC_SUB : ACC_ADD;

  muldiv_datapath #(.DATA_WIDTH(W)) u_datapath (
    .i_is_div    (r_is_div),
    .i_work      (r_work),
    .i_mcand     (r_mcand),
    .i_neg_p     (r_neg_p),
    .i_neg_r     (r_neg_r),
    .i_div0      (r_div0),
    .i_acc       (r_acc),
    .i_hi        (r_hi),
    .i_lo        (r_lo),
    .o_work_next (w_work_next),
    .o_hi_fix    (w_hi_fix),
    .o_lo_fix    (w_lo_fix)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state: accept in IDLE, iterate W times in CALC, one FIX cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = CALC;
      CALC:    if (r_cnt == CNT_LAST) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch at accept, then one datapath step per CALC cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_work   <= '0;
      r_mcand  <= '0;
      r_is_div <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_acc    <= ACC_NONE;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= w_is_div_in;
      r_work   <= {{W{1'b0}}, (w_is_div_in ? w_mag_a : w_mag_b)};
      r_mcand  <= w_is_div_in ? w_mag_b : w_mag_a;
      r_neg_p  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_div0   <= w_is_div_in && (bus.i_operand_b == '0);
      r_acc    <= w_acc_in;
    end else if (r_state == CALC) begin
      r_work   <= w_work_next;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // HI/LO: whole-result commit when leaving FIX, direct moves in IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      r_hi <= w_hi_fix;
      r_lo <= w_lo_fix;
    end else if (w_idle && bus.i_start) begin
      if (bus.i_op == OP_MTHI) r_hi <= bus.i_operand_a;
      if (bus.i_op == OP_MTLO) r_lo <= bus.i_operand_a;
    end
  end

  // Done pulses for the single cycle following the commit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_done <= 1'b0;
    else          r_done <= (r_state == FIX);
  end

  assign bus.o_busy  = !w_idle;
  assign bus.o_stall = !w_idle && (bus.i_hilo_read_req || bus.i_start);
  assign bus.o_done  = r_done;
  assign bus.o_hi    = r_hi;
  assign bus.o_lo    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: reset, mult/div results, stall
// behaviour, moves and (when MULDIV_MADD_EN is defined) MADD/MSUB.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  localparam int DATA_WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  hilo_muldiv_unit_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  hilo_muldiv_unit #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div-class op and check its full-latency timing and result
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.i_start     = 1'b1;
    bus.i_op        = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    tick();
    bus.i_start = 1'b0;
    chk({tag, "_busy_start"}, 32'(bus.o_busy), 32'd1);
    repeat (DATA_WIDTH) tick();
    chk({tag, "_done_early"}, 32'(bus.o_done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_hi"}, bus.o_hi, exp_hi);
    chk({tag, "_lo"}, bus.o_lo, exp_lo);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    bus.i_start     = 1'b1;
    bus.i_op        = op;
    bus.i_operand_a = a;
    bus.i_operand_b = 32'h0;
    tick();
    bus.i_start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks            = 0;
    n_err               = 0;
    rst_n               = 1'b0;
    bus.i_start         = 1'b0;
    bus.i_op            = 3'd0;
    bus.i_operand_a     = 32'h0;
    bus.i_operand_b     = 32'h0;
    bus.i_hilo_read_req = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_hi",    bus.o_hi, 32'h0);
    chk("rst_lo",    bus.o_lo, 32'h0);
    chk("rst_busy",  32'(bus.o_busy), 32'd0);
    chk("rst_done",  32'(bus.o_done), 32'd0);
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // Moves: single-cycle, never busy
    move(OP_MTHI, 32'hAAAA_5555);
    chk("mthi_hi", bus.o_hi, 32'hAAAA_5555);
    chk("mthi_busy", 32'(bus.o_busy), 32'd0);
    move(OP_MTLO, 32'h1234_5678);
    chk("mtlo_lo", bus.o_lo, 32'h1234_5678);
    chk("mtlo_hi_kept", bus.o_hi, 32'hAAAA_5555);
    chk("mtlo_busy", 32'(bus.o_busy), 32'd0);
    tick();
    chk("mtlo_busy_later", 32'(bus.o_busy), 32'd0);

    // Asynchronous reset in the middle of a MULT
    bus.i_start     = 1'b1;
    bus.i_op        = OP_MULT;
    bus.i_operand_a = 32'd7;
    bus.i_operand_b = 32'd9;
    tick();
    bus.i_start = 1'b0;
    repeat (10) tick();
    chk("abort_busy_before", 32'(bus.o_busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_hi",   bus.o_hi, 32'h0);
    chk("abort_lo",   bus.o_lo, 32'h0);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_done", 32'(bus.o_done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.o_done), 32'd0);
    end
    chk("abort_lo_after", bus.o_lo, 32'h0);

    // Multiply
    run_op("mult_m2x3",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_m2x3", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("mult_negneg", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // Divide
    run_op("div_m7d2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_7d0",   OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_m7d0",   OP_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_big",   OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);

    // Stall while EX reads HI/LO during a MULT; none in the Done cycle
    bus.i_start     = 1'b1;
    bus.i_op        = OP_MULT;
    bus.i_operand_a = 32'h0001_0000;
    bus.i_operand_b = 32'h0001_0000;
    tick();
    bus.i_start = 1'b0;
    #1;
    chk("stall_no_req", 32'(bus.o_stall), 32'd0);
    bus.i_hilo_read_req = 1'b1;
    #1;
    chk("stall_req", 32'(bus.o_stall), 32'd1);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      tick();
      chk("stall_hold", 32'(bus.o_stall), 32'd1);
    end
    tick();
    chk("stall_done", 32'(bus.o_done), 32'd1);
    chk("stall_released", 32'(bus.o_stall), 32'd0);
    chk("stall_read_hi", bus.o_hi, 32'h0000_0001);
    chk("stall_read_lo", bus.o_lo, 32'h0000_0000);
    bus.i_hilo_read_req = 1'b0;
    tick();

    // Start while busy: stalled and ignored until IDLE
    bus.i_start     = 1'b1;
    bus.i_op        = OP_MULT;
    bus.i_operand_a = 32'd3;
    bus.i_operand_b = 32'd4;
    tick();
    bus.i_op        = OP_MULTU;
    bus.i_operand_a = 32'd5;
    bus.i_operand_b = 32'd6;
    #1;
    chk("busy_start_stall", 32'(bus.o_stall), 32'd1);
    repeat (DATA_WIDTH) tick();
    chk("busy_start_stall_fix", 32'(bus.o_stall), 32'd1);
    tick();
    chk("busy_start_done1", 32'(bus.o_done), 32'd1);
    chk("busy_start_stall_idle", 32'(bus.o_stall), 32'd0);
    chk("busy_start_lo1", bus.o_lo, 32'd12);
    chk("busy_start_hi1", bus.o_hi, 32'd0);
    tick();
    bus.i_start = 1'b0;
    chk("busy_start_second_busy", 32'(bus.o_busy), 32'd1);
    repeat (DATA_WIDTH) tick();
    chk("busy_start_second_early", 32'(bus.o_done), 32'd0);
    tick();
    chk("busy_start_done2", 32'(bus.o_done), 32'd1);
    chk("busy_start_lo2", bus.o_lo, 32'd30);
    chk("busy_start_hi2", bus.o_hi, 32'd0);
    tick();

    // MADD / MSUB
    move(OP_MTHI, 32'd0);
    move(OP_MTLO, 32'd10);
`ifdef MULDIV_MADD_EN
    run_op("madd_3x4", OP_MADD, 32'd3, 32'd4, 32'h0000_0000, 32'd22);
    run_op("msub_5x5", OP_MSUB, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    bus.i_start     = 1'b1;
    bus.i_op        = OP_MADD;
    bus.i_operand_a = 32'd3;
    bus.i_operand_b = 32'd4;
    tick();
    bus.i_op = OP_MSUB;
    tick();
    bus.i_start = 1'b0;
    chk("madd_off_busy", 32'(bus.o_busy), 32'd0);
    chk("madd_off_hi", bus.o_hi, 32'd0);
    chk("madd_off_lo", bus.o_lo, 32'd10);
    tick();
    chk("madd_off_done", 32'(bus.o_done), 32'd0);
    chk("madd_off_busy2", 32'(bus.o_busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
